// File: rtl/mem_arbiter.sv
// Arbitrates an I-cache and a D-cache onto one memory port in 4-access bursts.
// Read data returns two cycles after acceptance and is routed back to the requester that issued it.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data_in,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] m_data_out,
  input  logic        m_stall,
  input  logic [3:0]  m_busy,
  input  logic        m_err,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_rd,
  output logic        m_wr,
  output logic [15:0] i_data_out,
  output logic [15:0] d_data_out,
  output logic        i_valid,
  output logic        d_valid,
  output logic        i_stall,
  output logic        d_stall,
  output logic        i_err,
  output logic        d_err,
  output logic        owner
);

  typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;
  logic       s0_v_q, s0_v_d, s0_o_q, s0_o_d;
  logic       s1_v_q, s1_v_d, s1_o_q, s1_o_d;

  logic i_req, d_req, has_own, own, own_req, accept;
  logic unused_busy;

  assign unused_busy = ^m_busy;
  assign i_req       = i_rd | i_wr;
  assign d_req       = d_rd | d_wr;

  // Owner selection: fixed while owning, combinational round-robin in idle.
  always_comb begin
    has_own = 1'b1;
    own     = 1'b0;
    unique case (state_q)
      StOwnI:  own = 1'b0;
      StOwnD:  own = 1'b1;
      default: begin
        has_own = i_req | d_req;
        own     = (i_req & d_req) ? ~rr_q : d_req;
      end
    endcase
  end

  always_comb begin
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    m_addr    = 16'h0000;
    m_data_in = 16'h0000;
    if (has_own) begin
      m_rd      = own ? d_rd : i_rd;
      m_wr      = own ? (d_wr & ~d_rd) : (i_wr & ~i_rd);
      m_addr    = own ? d_addr : i_addr;
      m_data_in = own ? d_data_in : i_data_in;
    end
  end

  assign own_req = own ? d_req : i_req;
  assign accept  = (m_rd | m_wr) & ~m_stall;
  assign owner   = own;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (state_q == StIdle) begin
      if (accept) begin
        state_d = own ? StOwnD : StOwnI;
        cnt_d   = 2'd1;
      end
    end else if (!own_req) begin
      state_d = StIdle;
      cnt_d   = 2'd0;
    end else if (accept) begin
      if (cnt_q == 2'd3) begin
        state_d = StIdle;
        cnt_d   = 2'd0;
        rr_d    = own;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Return pipeline tags each accepted read with its owner; never flushed on handover.
  always_comb begin
    s0_v_d = accept & m_rd;
    s0_o_d = own;
    s1_v_d = s0_v_q;
    s1_o_d = s0_o_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      rr_q    <= 1'b0;
      s0_v_q  <= 1'b0;
      s0_o_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      s1_o_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      s0_v_q  <= s0_v_d;
      s0_o_q  <= s0_o_d;
      s1_v_q  <= s1_v_d;
      s1_o_q  <= s1_o_d;
    end
  end

  assign i_valid    = s1_v_q & ~s1_o_q;
  assign d_valid    = s1_v_q & s1_o_q;
  assign i_data_out = i_valid ? m_data_out : 16'h0000;
  assign d_data_out = d_valid ? m_data_out : 16'h0000;

  // A requesting non-owner always waits; the owner sees the memory's own stall.
  assign i_stall = i_req & ((has_own & ~own) ? m_stall : 1'b1);
  assign d_stall = d_req & ((has_own & own) ? m_stall : 1'b1);
  assign i_err   = m_err & has_own & ~own & (m_rd | m_wr);
  assign d_err   = m_err & has_own & own & (m_rd | m_wr);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns into a queue,
// and a negedge monitor pops and compares whenever a return is presented.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, i_data_in, d_addr, d_data_in, m_data_out;
  logic        i_rd, i_wr, d_rd, d_wr, m_stall, m_err;
  logic [3:0]  m_busy;
  logic [15:0] m_addr, m_data_in, i_data_out, d_data_out;
  logic        m_rd, m_wr, i_valid, d_valid, i_stall, d_stall, i_err, d_err, owner;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [15:0] mem_q0, mem_q1;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_data_in(i_data_in), .i_rd(i_rd), .i_wr(i_wr),
    .d_addr(d_addr), .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr),
    .m_data_out(m_data_out), .m_stall(m_stall), .m_busy(m_busy), .m_err(m_err),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
    .i_data_out(i_data_out), .d_data_out(d_data_out), .i_valid(i_valid), .d_valid(d_valid),
    .i_stall(i_stall), .d_stall(d_stall), .i_err(i_err), .d_err(d_err), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory model: 2-cycle read latency, data derived from the address.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    mem_q0 <= (m_rd && !m_stall) ? mem_val(m_addr) : 16'h0000;
    mem_q1 <= mem_q0;
  end
  assign m_data_out = mem_q1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic o, input logic [15:0] a);
    exp_q.push_back({o, mem_val(a)});
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    chk("both_valid", {15'd0, i_valid & d_valid}, 16'h0000);
    if (i_valid || d_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_return: i_valid=%b d_valid=%b expected none at %0t",
                 i_valid, d_valid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("ret_owner", {15'd0, d_valid}, {15'd0, e[16]});
        chk("ret_data", d_valid ? d_data_out : i_data_out, e[15:0]);
      end
    end
    if (!i_valid) chk("i_data_zero", i_data_out, 16'h0000);
    if (!d_valid) chk("d_data_zero", d_data_out, 16'h0000);
  end

  // Check combinational outputs mid-cycle, then advance to 1ns after the next edge.
  task automatic cyc(input logic eo, input logic erd, input logic ewr, input logic [15:0] ea,
                     input logic eis, input logic eds);
    #3;
    chk("owner", {15'd0, owner}, {15'd0, eo});
    chk("m_rd", {15'd0, m_rd}, {15'd0, erd});
    chk("m_wr", {15'd0, m_wr}, {15'd0, ewr});
    if (erd || ewr) chk("m_addr", m_addr, ea);
    chk("i_stall", {15'd0, i_stall}, {15'd0, eis});
    chk("d_stall", {15'd0, d_stall}, {15'd0, eds});
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0; m_stall = 0; m_err = 0;
    i_addr = 0; d_addr = 0; i_data_in = 0; d_data_in = 0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_rd", {15'd0, m_rd}, 16'h0000);
    chk("rst_valids", {14'd0, i_valid, d_valid}, 16'h0000);
    rst = 0;
  endtask

  initial begin
    m_busy = 4'h0;
    do_reset();

    // Single D read burst; both rd+wr in word 2 must read; error routed to D.
    d_rd = 1;
    for (int k = 0; k < 4; k++) begin
      d_addr = 16'h0100 + 16'(2 * k);
      d_wr   = (k == 1);
      m_err  = (k == 1);
      if (k == 1) begin
        #2;
        chk("d_err", {15'd0, d_err}, 16'h0001);
        chk("i_err", {15'd0, i_err}, 16'h0000);
        #(-0);
      end
      if (k == 1) cyc(1, 1, 0, d_addr, 0, 0);
      else cyc(1, 1, 0, d_addr, 0, 0);
      push(1, d_addr);
    end
    clr();
    i_rd = 1; i_addr = 16'h0180;
    cyc(0, 1, 0, 16'h0180, 0, 0);
    push(0, 16'h0180);
    i_rd = 0;
    cyc(0, 0, 0, 16'h0, 0, 0);
    idle(3);

    // Tie from reset: D first, then I, then D again.
    do_reset();
    i_rd = 1; d_rd = 1;
    for (int k = 0; k < 4; k++) begin
      d_addr = 16'h0200 + 16'(2 * k);
      i_addr = 16'h0300;
      cyc(1, 1, 0, d_addr, 1, 0);
      push(1, d_addr);
    end
    d_addr = 16'h0280;
    for (int k = 0; k < 4; k++) begin
      i_addr = 16'h0300 + 16'(2 * k);
      cyc(0, 1, 0, i_addr, 0, 1);
      push(0, i_addr);
    end
    i_rd = 0;
    cyc(1, 1, 0, 16'h0280, 0, 0);
    push(1, 16'h0280);
    d_rd = 0;
    cyc(1, 0, 0, 16'h0, 0, 0);
    idle(3);

    // Memory stall on the second D access holds address and burst count.
    do_reset();
    d_rd = 1; d_addr = 16'h0400;
    cyc(1, 1, 0, 16'h0400, 0, 0);
    push(1, 16'h0400);
    d_addr = 16'h0402; m_stall = 1;
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 16'h0402, 0, 1);
    m_stall = 0;
    for (int k = 1; k < 4; k++) begin
      d_addr = 16'h0400 + 16'(2 * k);
      cyc(1, 1, 0, d_addr, 0, 0);
      push(1, d_addr);
    end
    i_rd = 1; i_addr = 16'h0480; d_addr = 16'h0408;
    cyc(0, 1, 0, 16'h0480, 0, 1);
    push(0, 16'h0480);
    clr();
    cyc(0, 0, 0, 16'h0, 0, 0);
    idle(3);

    // D write burst while I waits; I granted immediately afterwards.
    do_reset();
    i_rd = 1; i_addr = 16'h0500; d_wr = 1;
    for (int k = 0; k < 4; k++) begin
      d_addr    = 16'h0510 + 16'(2 * k);
      d_data_in = 16'hAAAA + 16'(k);
      #2;
      chk("m_data_in", m_data_in, 16'hAAAA + 16'(k));
      cyc(1, 0, 1, d_addr, 1, 0);
    end
    d_wr = 0;
    cyc(0, 1, 0, 16'h0500, 0, 0);
    push(0, 16'h0500);
    i_rd = 0;
    cyc(0, 0, 0, 16'h0, 0, 0);
    idle(3);

    // D drops after two reads; its returns still route to D.
    do_reset();
    i_rd = 1; i_addr = 16'h0700; d_rd = 1;
    for (int k = 0; k < 2; k++) begin
      d_addr = 16'h0600 + 16'(2 * k);
      cyc(1, 1, 0, d_addr, 1, 0);
      push(1, d_addr);
    end
    d_rd = 0; d_addr = 16'h0;
    cyc(1, 0, 0, 16'h0, 1, 0);
    cyc(0, 1, 0, 16'h0700, 0, 0);
    push(0, 16'h0700);
    i_rd = 0;
    cyc(0, 0, 0, 16'h0, 0, 0);
    idle(3);

    // Reset pulse right after an accepted read discards its return.
    do_reset();
    d_rd = 1; d_addr = 16'h0800;
    cyc(1, 1, 0, 16'h0800, 0, 0);
    clr();
    rst = 1;
    #3;
    chk("rst_mid_valid", {14'd0, i_valid, d_valid}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 0;
    idle(3);
    i_rd = 1; i_addr = 16'h0880; d_rd = 1; d_addr = 16'h0900;
    cyc(1, 1, 0, 16'h0900, 1, 0);
    push(1, 16'h0900);
    clr();
    cyc(1, 0, 0, 16'h0, 0, 0);
    idle(4);

    chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
